mac_operand_sequencer: RTL and testbench
========================================

# mac_operand_sequencer

Upstream control stage for the 4-bit MAC datapath. Buffers incoming operand pairs in a small FIFO behind a valid/ready handshake. On `start`, runs an FSM that issues `N_OPS` pairs to the datapath as exclusive one-cycle load strobes. It then requests the result with `load_out`, waits for the datapath's `done`, and reports completion.

## Interface
- `DEPTH`, default 4: operand FIFO depth; power of two, at least 2.
- `N_OPS`, default 10: operand pairs per run; legal range 1..18, so the accumulated sum stays at or below 4050 and fits the 12-bit accumulator.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset: synchronous, active-high.
- `start`  in  1  begin a run; sampled only in IDLE.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  FIFO can accept; equals `!full && !rst`.
- `in_a`  in  4  operand A.
- `in_b`  in  4  operand B.
- `A`  out  4  registered operand A to the datapath.
- `B`  out  4  registered operand B to the datapath.
- `load_a`, `load_b`  out  1 each  asserted together in LOAD_AB.
- `load_m`  out  1  asserted in LOAD_M.
- `load_acc`  out  1  asserted in LOAD_ACC.
- `load_out`  out  1  asserted in OUT.
- `count_enable`  out  1  asserted in LOAD_AB.
- `done`  in  1  result-valid level from the datapath.
- `busy`  out  1  high in any state other than IDLE.
- `run_done`  out  1  one-cycle pulse in FINISH.
- `fifo_count`  out  clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- **FIFO**
  - Push on `in_valid && in_ready`.
  - Pop only in FETCH when not empty.
  - Simultaneous push and pop leaves `fifo_count` unchanged.
  - Pointers wrap modulo DEPTH.
  - Data is first-in first-out.
  - `in_valid` while full is ignored; no push, no corruption.
- **FSM states:** IDLE, FETCH, LOAD_AB, LOAD_M, LOAD_ACC, OUT, WAIT_DONE, FINISH.
- **Transitions:**
  - IDLE: `start` → FETCH.
  - FETCH: not empty → pop, register head into `A`/`B`, go to LOAD_AB. Empty → stay in FETCH with all strobes low.
  - LOAD_AB → LOAD_M → LOAD_ACC.
  - LOAD_ACC: increment `op_cnt`. If `op_cnt == N_OPS-1` → OUT, else → FETCH.
  - OUT → WAIT_DONE.
  - WAIT_DONE: `done` high → FINISH.
  - FINISH: clear `op_cnt`, go to IDLE.
- **Strobes:**
  - All strobes are registered and decoded from the next state, so each is high exactly during its state.
  - At most one of `{load_a&load_b, load_m, load_acc, load_out}` is high in any cycle.
  - All strobes are low in IDLE, FETCH, WAIT_DONE and FINISH.
- **Operand hold:** `A`/`B` hold their last value until the next pop, including through LOAD_M and LOAD_ACC.
- **`op_cnt`:** internal, width clog2(N_OPS+1), reset 0. It never exceeds N_OPS-1.
- **`start` handling:** ignored while `busy`. Not latched.
- **Datapath `cmp`:** not used; the run length is owned here.

## Timing
- **Reset:** with `rst` high at an edge, the next state is:
  - FSM in IDLE; FIFO flushed with pointers 0 and `fifo_count` 0.
  - `op_cnt` 0; `A`/`B` 0.
  - All strobes, `busy` and `run_done` 0.
  - `in_ready` is 0 while `rst` is high.
- **Reset mid-run:** same result from any state. Any partial run is abandoned and strobes drop on the next edge.
- **Start:** `start` sampled high in IDLE at edge k gives `busy`=1 from k+1, with FETCH in cycle k+1.
- **Per operand, FIFO non-empty:** 4 cycles (FETCH, LOAD_AB, LOAD_M, LOAD_ACC). `load_a`/`load_b` assert the cycle after the pop.
- **Run length with FIFO pre-filled and `done` returned one cycle after `load_out`:**
  - 4·N_OPS + 3 busy cycles.
  - N_OPS=10 gives 43 cycles.
  - `run_done` is high in the last busy cycle; `busy` drops the following cycle.
- **Empty FIFO:** each empty cycle in FETCH adds one stall cycle. There is no timeout.
- **`done` already high on entering WAIT_DONE:** proceed to FINISH the next cycle.
- **Handshake:** push accepted at an edge appears in `fifo_count` the next cycle. A pop in the same cycle as a push to an empty FIFO cannot happen, because FETCH sees empty that cycle.

## Test plan
- **Reset values:** assert `rst` for 2 cycles with `in_valid`=1. Required: every output is 0, `fifo_count`=0 and `in_ready`=0 during reset, and nothing is pushed.
- **Full run:** push pairs (1,1),(2,2)…(10,10), pulse `start`, return `done` one cycle after `load_out`. Required:
  - `A`/`B` sequence 1..10 in order.
  - Exactly 10 LOAD_AB, 10 LOAD_M and 10 LOAD_ACC pulses, then one `load_out`.
  - `run_done` at busy cycle 43.
  - Datapath `out` = 385.
- **FIFO full:** push 4 pairs with DEPTH=4. Required: `in_ready`=0 and a fifth push is ignored. After one pop, `in_ready`=1 and order is preserved.
- **Starved FIFO:** `start` with FIFO empty, first pair pushed 5 cycles later. Required: FSM held in FETCH with strobes low for those cycles, then normal sequence; busy time increases by exactly the stall count.
- **Reset mid-run:** `rst` asserted while in LOAD_M of operand 3. Required: IDLE and FIFO empty next cycle, no `load_out`, and a fresh run afterwards matches the full-run expectations.
- **Wrap and overlap:** `start` re-asserted while busy is ignored. Running two back-to-back runs with continuous pushes exercises pointer wrap; required: second-run sum correct, e.g. ten pairs of (15,15) gives accumulator output 2250.

Source files
------------

// File: rtl/mac_operand_sequencer.sv
// Operand sequencer for the 4-bit MAC datapath: a small operand FIFO behind a
// valid/ready handshake, and an FSM that strobes N_OPS pairs into the datapath per run.
module mac_operand_sequencer #(
  parameter int DEPTH = 4,
  parameter int N_OPS = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_a,
  input  logic [3:0]               in_b,
  output logic [3:0]               A,
  output logic [3:0]               B,
  output logic                     load_a,
  output logic                     load_b,
  output logic                     load_m,
  output logic                     load_acc,
  output logic                     load_out,
  output logic                     count_enable,
  input  logic                     done,
  output logic                     busy,
  output logic                     run_done,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int DATA_W = 4;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(N_OPS + 1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_OP  = CNT_W'(N_OPS - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD_AB, LOAD_M, LOAD_ACC, OUT, WAIT_DONE, FINISH
  } state_t;

  state_t state, state_n;

  logic [DATA_W-1:0] mem_a [DEPTH];
  logic [DATA_W-1:0] mem_b [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  op_cnt;
  logic              full, empty, push, pop;

  assign full     = (fifo_count == FULL_CNT);
  assign empty    = (fifo_count == '0);
  assign in_ready = !full && !rst;
  assign push     = in_valid && in_ready;
  assign pop      = (state == FETCH) && !empty;
  assign busy     = (state != IDLE);

  // Operand FIFO: pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= in_a;
      mem_b[wr_ptr] <= in_b;
    end
  end

  // Operand register: holds the popped pair until the next pop
  always_ff @(posedge clk) begin
    if (rst) begin
      A <= '0;
      B <= '0;
    end else if (pop) begin
      A <= mem_a[rd_ptr];
      B <= mem_b[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_cnt <= '0;
    end else if (state == LOAD_ACC && op_cnt != LAST_OP) begin
      op_cnt <= op_cnt + 1'b1;
    end else if (state == FINISH) begin
      op_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (start) state_n = FETCH;
      FETCH:     if (!empty) state_n = LOAD_AB;
      LOAD_AB:   state_n = LOAD_M;
      LOAD_M:    state_n = LOAD_ACC;
      LOAD_ACC:  state_n = (op_cnt == LAST_OP) ? OUT : FETCH;
      OUT:       state_n = WAIT_DONE;
      WAIT_DONE: if (done) state_n = FINISH;
      FINISH:    state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  // Strobes decode the next state so each is registered and aligned with its state
  always_ff @(posedge clk) begin
    if (rst) begin
      load_a       <= 1'b0;
      load_b       <= 1'b0;
      load_m       <= 1'b0;
      load_acc     <= 1'b0;
      load_out     <= 1'b0;
      count_enable <= 1'b0;
      run_done     <= 1'b0;
    end else begin
      load_a       <= (state_n == LOAD_AB);
      load_b       <= (state_n == LOAD_AB);
      load_m       <= (state_n == LOAD_M);
      load_acc     <= (state_n == LOAD_ACC);
      load_out     <= (state_n == OUT);
      count_enable <= (state_n == LOAD_AB);
      run_done     <= (state_n == FINISH);
    end
  end

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Bench for mac_operand_sequencer: feeds operand pairs through a scoreboard, models the
// MAC datapath to form the run sum, and checks strobe sequencing and run timing.
module tb_mac_operand_sequencer;

  logic       clk, rst, start, in_valid, in_ready, done;
  logic [3:0] in_a, in_b, A, B;
  logic       load_a, load_b, load_m, load_acc, load_out, count_enable, busy, run_done;
  logic [2:0] fifo_count;

  mac_operand_sequencer #(.DEPTH(4), .N_OPS(10)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .A(A), .B(B), .load_a(load_a), .load_b(load_b),
    .load_m(load_m), .load_acc(load_acc), .load_out(load_out),
    .count_enable(count_enable), .done(done), .busy(busy), .run_done(run_done),
    .fifo_count(fifo_count)
  );

  typedef struct { logic [3:0] a; logic [3:0] b; } pair_t;
  typedef struct { int a0; int da; int b0; int db; int sum; } vec_t;

  pair_t to_send[$];
  pair_t sb[$];
  vec_t  tbl[6];

  int tests = 0;
  int fails = 0;
  bit feed_en = 0;

  int cnt_ab, cnt_m, cnt_acc, cnt_out, busy_cyc, busy_at_done, acc, prod, out_val;
  bit run_complete, done_pend;
  logic [3:0] ra, rb;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic clear_stats();
    cnt_ab = 0; cnt_m = 0; cnt_acc = 0; cnt_out = 0;
    busy_cyc = 0; busy_at_done = -1; acc = 0; prod = 0; out_val = -1;
    run_complete = 0;
  endtask

  task automatic load_pairs(input int a0, input int da, input int b0, input int db);
    pair_t p;
    for (int i = 0; i < 10; i++) begin
      p.a = 4'((a0 + da * i) & 15);
      p.b = 4'((b0 + db * i) & 15);
      to_send.push_back(p);
    end
  endtask

  // Feeder: presents the head of to_send; a handshake seen mid-cycle is a push at the next edge
  initial begin
    in_valid = 1'b0; in_a = '0; in_b = '0;
    forever begin
      @(negedge clk);
      if (feed_en && to_send.size() > 0) begin
        in_valid = 1'b1;
        in_a = to_send[0].a;
        in_b = to_send[0].b;
      end else begin
        in_valid = 1'b0;
      end
      #3;
      if (in_valid && in_ready && to_send.size() > 0) sb.push_back(to_send.pop_front());
    end
  end

  // Monitor and datapath model
  initial begin
    pair_t e;
    int    n;
    done = 1'b0;
    done_pend = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        done = 1'b0;
        done_pend = 0;
      end else begin
        if (busy) busy_cyc++;
        if (load_a | load_b | load_m | load_acc | load_out | count_enable) begin
          n = int'(load_a & load_b) + int'(load_m) + int'(load_acc) + int'(load_out);
          check("strobe_onehot", int'(n == 1 && load_a == load_b && count_enable == load_a), 1);
        end
        if (load_a) begin
          cnt_ab++;
          if (sb.size() == 0) begin
            check("sb_underflow", 1, 0);
          end else begin
            e = sb.pop_front();
            check("operand_AB", int'({A, B}), int'({e.a, e.b}));
            ra = e.a;
            rb = e.b;
          end
        end
        if (load_m) begin
          cnt_m++;
          check("hold_m", int'({A, B}), int'({ra, rb}));
          prod = int'(ra) * int'(rb);
        end
        if (load_acc) begin
          cnt_acc++;
          check("hold_acc", int'({A, B}), int'({ra, rb}));
          acc += prod;
        end
        if (load_out) begin
          cnt_out++;
          out_val = acc;
          done_pend = 1;
        end else if (done_pend) begin
          done = 1'b1;
          done_pend = 0;
        end
        if (run_done) begin
          busy_at_done = busy_cyc;
          run_complete = 1;
          done = 1'b0;
        end
      end
    end
  end

  task automatic wait_run(input string tag, input int exp_sum, input int exp_busy);
    int k = 0;
    while (!run_complete && k < 300) begin step(); k++; end
    check({tag, "_timeout"}, int'(run_complete), 1);
    check({tag, "_n_ab"}, cnt_ab, 10);
    check({tag, "_n_m"}, cnt_m, 10);
    check({tag, "_n_acc"}, cnt_acc, 10);
    check({tag, "_n_out"}, cnt_out, 1);
    check({tag, "_busy_cycles"}, busy_at_done, exp_busy);
    check({tag, "_sum"}, out_val, exp_sum);
    step();
    check({tag, "_busy_drop"}, int'({busy, run_done}), 0);
  endtask

  task automatic prefill_and_start(input string tag);
    int k = 0;
    feed_en = 1;
    while (fifo_count != 3'd4 && k < 20) begin step(); k++; end
    step(); step();
    check({tag, "_full"}, int'({in_ready, fifo_count}), 4);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_table(input int idx, input string tag);
    int k = 0;
    clear_stats();
    load_pairs(tbl[idx].a0, tbl[idx].da, tbl[idx].b0, tbl[idx].db);
    prefill_and_start(tag);
    while (cnt_ab < 1 && k < 20) begin step(); k++; end
    check({tag, "_after_pop"}, int'({in_ready, fifo_count}), 8 + 3);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_run(tag, tbl[idx].sum, 43);
    feed_en = 0;
  endtask

  initial begin
    int k;
    tbl[0] = '{a0: 1,  da: 1,  b0: 1,  db: 1,  sum: 385};
    tbl[1] = '{a0: 15, da: 0,  b0: 15, db: 0,  sum: 2250};
    tbl[2] = '{a0: 0,  da: 1,  b0: 0,  db: 0,  sum: 0};
    tbl[3] = '{a0: 3,  da: 0,  b0: 1,  db: 1,  sum: 165};
    tbl[4] = '{a0: 15, da: -1, b0: 1,  db: 0,  sum: 105};
    tbl[5] = '{a0: 6,  da: 1,  b0: 15, db: -1, sum: 1020};

    rst = 1'b1;
    start = 1'b0;
    clear_stats();
    to_send.push_back('{a: 4'd7, b: 4'd7});
    feed_en = 1;

    // Reset held two cycles with a pair presented
    step(); step();
    check("rst_outputs", int'({A, B, load_a, load_b, load_m, load_acc, load_out,
                               count_enable, busy, run_done}), 0);
    check("rst_ready_count", int'({in_ready, fifo_count}), 0);
    feed_en = 0;
    step();
    to_send.delete();
    rst = 1'b0;
    step();
    check("rst_no_push", int'(fifo_count), 0);
    check("rst_sb_empty", sb.size(), 0);

    for (int i = 0; i < 6; i++) run_table(i, $sformatf("run%0d", i));

    // Starved FIFO: five extra FETCH cycles before the first pair arrives
    clear_stats();
    load_pairs(1, 1, 1, 1);
    feed_en = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("stall_fetch", int'({load_a, load_b, load_m, load_acc, load_out, count_enable,
                                 busy, fifo_count}), 8);
      if (i < 3) step();
    end
    feed_en = 1;
    wait_run("stall", 385, 48);
    feed_en = 0;

    // Reset during LOAD_M of the third operand
    clear_stats();
    load_pairs(1, 1, 1, 1);
    prefill_and_start("midrst");
    k = 0;
    while (cnt_m < 3 && k < 40) begin step(); k++; end
    check("midrst_in_load_m", int'(load_m), 1);
    rst = 1'b1;
    step();
    check("midrst_idle", int'({A, B, load_a, load_b, load_m, load_acc, load_out,
                               count_enable, busy, run_done}), 0);
    check("midrst_fifo", int'({in_ready, fifo_count}), 0);
    feed_en = 0;
    to_send.delete();
    sb.delete();
    step();
    rst = 1'b0;
    step(); step(); step();
    check("midrst_no_out", cnt_out, 0);
    check("midrst_stays_idle", int'(busy), 0);

    run_table(0, "fresh");
    run_table(1, "wrap");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
